fwd_hazard_unit: RTL and testbench

Parametrised successor to the combinational E/M forwarding unit. Combines per-operand forwarding selection for NSRC source operands with a sequential hazard controller: a load-use stall sequencer with configurable load latency and a scoreboard for one multi-cycle (MUL/DIV) unit with a completion-cycle bypass. Sits beside the decode stage and drives the operand muxes plus the F/D hold and E bubble-insert controls.

---
 rtl/fwd_hazard_unit.sv | 127 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select plus load-use / multi-cycle-unit hazard control.
// Drives the decode-side operand muxes and the F/D hold and E bubble-insert controls.
module fwd_hazard_unit #(
    parameter int AW      = 5,
    parameter int NSRC    = 2,
    parameter int LD_LAT  = 1,
    parameter int MUL_LAT = 4,
    parameter int CW      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSRC*AW-1:0] iRs_RegD,
    input  logic [NSRC-1:0]   iRsUse_RegD,
    input  logic [AW-1:0]     iwsel_RegD,
    input  logic              iMulIssue_RegD,
    input  logic              iRegWrite_RegE,
    input  logic              iMemRead_RegE,
    input  logic [AW-1:0]     iwsel_RegE,
    input  logic              iRegWrite_RegM,
    input  logic [AW-1:0]     iwsel_RegM,
    input  logic              iPipeHold,
    output logic [2*NSRC-1:0] oFU_Sel,
    output logic              oStall_D,
    output logic              oBubble_E,
    output logic              oMulBusy,
    output logic              oMulDone,
    output logic [CW-1:0]     oStallCnt
);

    localparam int LCW = 3;
    localparam int MCW = 4;

    typedef enum logic [1:0] {
        IDLE,
        LD_STALL,
        MUL_WAIT
    } hazState_t;

    hazState_t       state, stateNext;
    logic [LCW-1:0]  ldCnt, ldCntNext;
    logic [MCW-1:0]  mulCnt;
    logic [AW-1:0]   mulDest;

    logic [NSRC-1:0] loadDep, mulDep;
    logic            loadUse, mulHazard, mulAccept;

    assign oMulBusy = (mulCnt != '0);
    assign oMulDone = (mulCnt == MCW'(1));

    // Per-operand compare; register 0 never matches anything.
    for (genvar k = 0; k < NSRC; k++) begin : gSrc
        logic [AW-1:0] rs;
        logic          hitE, hitM, hitMul;
        assign rs      = iRs_RegD[k*AW +: AW];
        assign hitE    = (rs != '0) && iRegWrite_RegE && (rs == iwsel_RegE);
        assign hitM    = (rs != '0) && iRegWrite_RegM && (rs == iwsel_RegM);
        assign hitMul  = (rs != '0) && oMulDone && (rs == mulDest);
        assign loadDep[k] = iRsUse_RegD[k] && (rs != '0) && (rs == iwsel_RegE);
        assign mulDep[k]  = iRsUse_RegD[k] && (rs != '0) && (rs == mulDest);
        assign oFU_Sel[2*k +: 2] = hitE   ? 2'b10 :
                                   hitM   ? 2'b01 :
                                   hitMul ? 2'b11 : 2'b00;
    end

    assign loadUse   = iMemRead_RegE && iRegWrite_RegE && (iwsel_RegE != '0) && (|loadDep);
    assign mulHazard = oMulBusy && !oMulDone && ((|mulDep) || iMulIssue_RegD);
    assign mulAccept = iMulIssue_RegD && !oStall_D && !iPipeHold;
    assign oBubble_E = oStall_D;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        stateNext = state;
        ldCntNext = ldCnt;
        oStall_D  = 1'b0;
        case (state)
            IDLE: begin
                if (loadUse) begin
                    oStall_D = 1'b1;
                    if (LD_LAT > 1) begin
                        stateNext = LD_STALL;
                        ldCntNext = LCW'(LD_LAT - 1);
                    end
                end else if (mulHazard) begin
                    oStall_D  = 1'b1;
                    stateNext = MUL_WAIT;
                end
            end
            LD_STALL: begin
                oStall_D  = 1'b1;
                ldCntNext = ldCnt - 1'b1;
                if (ldCnt == LCW'(1)) stateNext = IDLE;
            end
            MUL_WAIT: begin
                // Released on the done cycle: the operand takes the MUL bypass.
                if (mulHazard) oStall_D = 1'b1;
                else           stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ldCnt     <= '0;
            mulCnt    <= '0;
            mulDest   <= '0;
            oStallCnt <= '0;
        end else begin
            if (!iPipeHold) begin
                state <= stateNext;
                ldCnt <= ldCntNext;
            end
            // Counter loads one short so the result is valid MUL_LAT-1 cycles after issue.
            if (mulAccept) begin
                mulCnt  <= MCW'(MUL_LAT - 1);
                mulDest <= iwsel_RegD;
            end else if (oMulBusy) begin
                mulCnt <= mulCnt - 1'b1;
            end
            if (oStall_D && !iPipeHold && (oStallCnt != '1))
                oStallCnt <= oStallCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: instance A (LD_LAT=1, CW=16) and instance B (LD_LAT=3, CW=4)
// share stimulus; each vector names which instance it checks.
module tb_fwd_hazard_unit;

    localparam int AW = 5;
    localparam int NSRC = 2;
    localparam int DA = 0;
    localparam int DB = 1;
    localparam int DN = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n, pipeHold, mulIssue, regWriteE, memReadE, regWriteM;
    logic [NSRC*AW-1:0]  rsD;
    logic [NSRC-1:0]     rsUse;
    logic [AW-1:0]       wselD, wselE, wselM;

    logic [3:0]  selA, selB;
    logic        stallA, bubA, busyA, doneA, stallB, bubB, busyB, doneB;
    logic [15:0] cntA;
    logic [3:0]  cntB;

    fwd_hazard_unit #(.AW(AW), .NSRC(NSRC), .LD_LAT(1), .MUL_LAT(4), .CW(16)) dutA (
        .clk(clk), .rst_n(rst_n), .iRs_RegD(rsD), .iRsUse_RegD(rsUse), .iwsel_RegD(wselD),
        .iMulIssue_RegD(mulIssue), .iRegWrite_RegE(regWriteE), .iMemRead_RegE(memReadE),
        .iwsel_RegE(wselE), .iRegWrite_RegM(regWriteM), .iwsel_RegM(wselM), .iPipeHold(pipeHold),
        .oFU_Sel(selA), .oStall_D(stallA), .oBubble_E(bubA), .oMulBusy(busyA),
        .oMulDone(doneA), .oStallCnt(cntA));

    fwd_hazard_unit #(.AW(AW), .NSRC(NSRC), .LD_LAT(3), .MUL_LAT(4), .CW(4)) dutB (
        .clk(clk), .rst_n(rst_n), .iRs_RegD(rsD), .iRsUse_RegD(rsUse), .iwsel_RegD(wselD),
        .iMulIssue_RegD(mulIssue), .iRegWrite_RegE(regWriteE), .iMemRead_RegE(memReadE),
        .iwsel_RegE(wselE), .iRegWrite_RegM(regWriteM), .iwsel_RegM(wselM), .iPipeHold(pipeHold),
        .oFU_Sel(selB), .oStall_D(stallB), .oBubble_E(bubB), .oMulBusy(busyB),
        .oMulDone(doneB), .oStallCnt(cntB));

    typedef struct {
        logic       rst, hold;
        logic [4:0] rs1, rs0;
        logic [1:0] rsu;
        logic [4:0] wD;
        logic       mi, weE, mrE;
        logic [4:0] wE;
        logic       weM;
        logic [4:0] wM;
        int         dut;
        logic [3:0] sel;
        logic       st, busy, done;
        int         cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t expQ[$];
    int   satQ[$];
    int   nCmp = 0;
    int   nBad = 0;

    function automatic vec_t mk(logic rst, logic hold, logic [4:0] rs1, logic [4:0] rs0,
                                logic [1:0] rsu, logic [4:0] wD, logic mi, logic weE,
                                logic mrE, logic [4:0] wE, logic weM, logic [4:0] wM,
                                int dut, logic [3:0] sel, logic st, logic busy,
                                logic done, int cnt);
        vec_t v;
        v.rst = rst; v.hold = hold; v.rs1 = rs1; v.rs0 = rs0; v.rsu = rsu; v.wD = wD;
        v.mi = mi; v.weE = weE; v.mrE = mrE; v.wE = wE; v.weM = weM; v.wM = wM;
        v.dut = dut; v.sel = sel; v.st = st; v.busy = busy; v.done = done; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst_n = v.rst; pipeHold = v.hold; rsD = {v.rs1, v.rs0}; rsUse = v.rsu;
        wselD = v.wD; mulIssue = v.mi; regWriteE = v.weE; memReadE = v.mrE;
        wselE = v.wE; regWriteM = v.weM; wselM = v.wM;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        logic [3:0]  aSel;
        logic        aSt, aBu, aBy, aDn;
        logic [31:0] aCnt;

        // rst hold rs1 rs0 use wD mi weE mrE wE weM wM | dut sel stall busy done cnt
        vecs.push_back(mk(1,0, 0,0,2'b00, 0,0, 0,0,0, 0,0, DA, 4'b0000,0,0,0,0));
        vecs.push_back(mk(1,0, 0,0,2'b00, 0,0, 0,0,0, 0,0, DB, 4'b0000,0,0,0,0));
        // forwarding priority E > M, register 0 ignored, second operand
        vecs.push_back(mk(1,0, 0,5,2'b01, 0,0, 1,0,5, 1,5, DA, 4'b0010,0,0,0,0));
        vecs.push_back(mk(1,0, 0,5,2'b01, 0,0, 0,0,5, 1,5, DA, 4'b0001,0,0,0,0));
        vecs.push_back(mk(1,0, 0,0,2'b01, 0,0, 1,0,0, 1,0, DA, 4'b0000,0,0,0,0));
        vecs.push_back(mk(1,0, 6,5,2'b11, 0,0, 1,0,6, 1,5, DA, 4'b1001,0,0,0,0));
        // load-use, LD_LAT=1
        vecs.push_back(mk(1,0, 0,3,2'b01, 0,0, 1,1,3, 0,0, DA, 4'b0010,1,0,0,0));
        vecs.push_back(mk(1,0, 0,3,2'b01, 0,0, 0,0,0, 1,3, DA, 4'b0001,0,0,0,1));
        vecs.push_back(mk(0,0, 0,0,2'b00, 0,0, 0,0,0, 0,0, DN, 4'b0000,0,0,0,0));
        // load-use, LD_LAT=3
        vecs.push_back(mk(1,0, 0,3,2'b01, 0,0, 1,1,3, 0,0, DB, 4'b0010,1,0,0,0));
        vecs.push_back(mk(1,0, 0,3,2'b01, 0,0, 0,0,0, 1,3, DB, 4'b0001,1,0,0,1));
        vecs.push_back(mk(1,0, 0,3,2'b01, 0,0, 0,0,0, 0,0, DB, 4'b0000,1,0,0,2));
        vecs.push_back(mk(1,0, 0,3,2'b01, 0,0, 0,0,0, 0,0, DB, 4'b0000,0,0,0,3));
        vecs.push_back(mk(0,0, 0,0,2'b00, 0,0, 0,0,0, 0,0, DN, 4'b0000,0,0,0,0));
        // MUL r7 issue, dependent read, bypass on done cycle
        vecs.push_back(mk(1,0, 0,0,2'b00, 7,1, 0,0,0, 0,0, DA, 4'b0000,0,0,0,0));
        vecs.push_back(mk(1,0, 0,7,2'b01, 0,0, 0,0,0, 0,0, DA, 4'b0000,1,1,0,0));
        vecs.push_back(mk(1,0, 0,7,2'b01, 0,0, 0,0,0, 0,0, DA, 4'b0000,1,1,0,1));
        vecs.push_back(mk(1,0, 0,7,2'b01, 0,0, 0,0,0, 0,0, DA, 4'b0011,0,1,1,2));
        vecs.push_back(mk(1,0, 0,7,2'b01, 0,0, 0,0,0, 0,0, DA, 4'b0000,0,0,0,2));
        // back-to-back MUL: second accepted on the first one's done cycle
        vecs.push_back(mk(1,0, 0,0,2'b00, 8,1, 0,0,0, 0,0, DA, 4'b0000,0,0,0,2));
        vecs.push_back(mk(1,0, 0,0,2'b00, 9,1, 0,0,0, 0,0, DA, 4'b0000,1,1,0,2));
        vecs.push_back(mk(1,0, 0,0,2'b00, 9,1, 0,0,0, 0,0, DA, 4'b0000,1,1,0,3));
        vecs.push_back(mk(1,0, 0,0,2'b00, 9,1, 0,0,0, 0,0, DA, 4'b0000,0,1,1,4));
        vecs.push_back(mk(1,0, 0,0,2'b00, 0,0, 0,0,0, 0,0, DA, 4'b0000,0,1,0,4));
        vecs.push_back(mk(1,0, 9,0,2'b10, 0,0, 0,0,0, 0,0, DA, 4'b0000,1,1,0,4));
        vecs.push_back(mk(1,0, 9,0,2'b10, 0,0, 0,0,0, 0,0, DA, 4'b1100,0,1,1,5));
        // MUL to r0 occupies the unit but is never a hazard or bypass source
        vecs.push_back(mk(1,0, 0,0,2'b00, 0,1, 0,0,0, 0,0, DA, 4'b0000,0,0,0,5));
        vecs.push_back(mk(1,0, 0,0,2'b01, 0,0, 0,0,0, 0,0, DA, 4'b0000,0,1,0,5));
        vecs.push_back(mk(1,0, 0,0,2'b01, 0,0, 0,0,0, 0,0, DA, 4'b0000,0,1,0,5));
        vecs.push_back(mk(1,0, 0,0,2'b01, 0,0, 0,0,0, 0,0, DA, 4'b0000,0,1,1,5));
        vecs.push_back(mk(0,0, 0,0,2'b00, 0,0, 0,0,0, 0,0, DN, 4'b0000,0,0,0,0));
        // hold freezes LD_STALL, then reset lands mid-stall with hold high
        vecs.push_back(mk(1,0, 0,3,2'b01, 0,0, 1,1,3, 0,0, DB, 4'b0010,1,0,0,0));
        vecs.push_back(mk(1,1, 0,3,2'b01, 0,0, 0,0,0, 0,0, DB, 4'b0000,1,0,0,1));
        vecs.push_back(mk(1,0, 0,3,2'b01, 0,0, 0,0,0, 0,0, DB, 4'b0000,1,0,0,1));
        vecs.push_back(mk(0,1, 0,3,2'b01, 0,0, 0,0,0, 0,0, DB, 4'b0000,1,0,0,2));
        vecs.push_back(mk(1,0, 0,0,2'b00, 0,0, 0,0,0, 0,0, DB, 4'b0000,0,0,0,0));
        vecs.push_back(mk(1,0, 0,0,2'b00, 0,0, 0,0,0, 0,0, DA, 4'b0000,0,0,0,0));
        // hold blocks MUL acceptance
        vecs.push_back(mk(1,1, 0,0,2'b00, 7,1, 0,0,0, 0,0, DA, 4'b0000,0,0,0,0));
        vecs.push_back(mk(1,0, 0,0,2'b00, 0,0, 0,0,0, 0,0, DA, 4'b0000,0,0,0,0));

        drive(mk(0,0, 0,0,2'b00, 0,0, 0,0,0, 0,0, DN, 4'b0000,0,0,0,0));
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            expQ.push_back(vecs[i]);
            @(negedge clk);
            e = expQ.pop_front();
            if (e.dut != DN) begin
                if (e.dut == DA) begin
                    aSel = selA; aSt = stallA; aBu = bubA; aBy = busyA; aDn = doneA; aCnt = 32'(cntA);
                end else begin
                    aSel = selB; aSt = stallB; aBu = bubB; aBy = busyB; aDn = doneB; aCnt = 32'(cntB);
                end
                check($sformatf("v%0d.sel", i),    32'(aSel), 32'(e.sel));
                check($sformatf("v%0d.stall", i),  32'(aSt),  32'(e.st));
                check($sformatf("v%0d.bubble", i), 32'(aBu),  32'(e.st));
                check($sformatf("v%0d.busy", i),   32'(aBy),  32'(e.busy));
                check($sformatf("v%0d.done", i),   32'(aDn),  32'(e.done));
                check($sformatf("v%0d.cnt", i),    aCnt,      32'(e.cnt));
            end
        end

        // Saturation: continuous load-use keeps both instances stalled every cycle.
        @(posedge clk);
        #1;
        drive(mk(0,0, 0,0,2'b00, 0,0, 0,0,0, 0,0, DN, 4'b0000,0,0,0,0));
        for (int i = 0; i < 20; i++) begin
            int n;
            @(posedge clk);
            #1;
            drive(mk(1,0, 0,3,2'b01, 0,0, 1,1,3, 0,0, DN, 4'b0000,0,0,0,0));
            satQ.push_back(i);
            @(negedge clk);
            n = satQ.pop_front();
            check($sformatf("sat%0d.cntB", n), 32'(cntB), (n > 15) ? 32'd15 : 32'(n));
            check($sformatf("sat%0d.cntA", n), 32'(cntA), 32'(n));
            check($sformatf("sat%0d.stallB", n), 32'(stallB), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
